run_ctrl: RTL and testbench

//  Synthesisable run controller for core-level simulation and FPGA bring-up of the pipelined cores.
//  - Sequences the core reset.
//  - Counts cycles and retired instructions.
//  - Detects program end, i.e. a self-loop such as 0x0000006f repeatedly retiring at one PC.
//  - Flags timeouts.
//  - Sits between the top-level reset/clock and the core; watches o_pc_debug/o_insn_vld.

---
 rtl/run_ctrl.sv | 138 +++++++++++++
 tb/tb_run_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// Run controller: sequences core reset, counts RUN cycles/retirements, flags HALTED/TIMEOUT/HUNG.
// Latency: every output is registered and updates on the edge that sees the triggering input.
// Backpressure: none; i_restart overrides everything. Optional HUNG detection under `RUN_CTRL_STALL_EN.
module run_ctrl #(
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int HALT_REPEAT    = 4,
    parameter int STALL_LIMIT    = 64,
    parameter int CNT_W          = 32
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_restart,
    input  logic [31:0]      i_pc_debug,
    input  logic             i_insn_vld,
    output logic             o_core_rstn,
    output logic             o_done,
    output logic [1:0]       o_status,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_retire_cnt,
    output logic [31:0]      o_halt_pc
);

    localparam int HOLD_W = $clog2(RST_CYCLES + 1);
    localparam int RPT_W  = $clog2(HALT_REPEAT + 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_RUN,
        S_HALTED,
        S_TIMEOUT,
        S_HUNG
    } state_t;

    state_t             state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [31:0]        last_pc;
    logic [RPT_W-1:0]   rpt;
    logic [RPT_W-1:0]   rpt_nxt;
    logic [CNT_W-1:0]   cycle_inc;
    logic [CNT_W-1:0]   retire_inc;
    logic               halt_hit;
    logic               tmo_hit;
    logic               hung_hit;

    assign cycle_inc  = (o_cycle_cnt  == '1) ? o_cycle_cnt  : o_cycle_cnt  + 1'b1;
    assign retire_inc = (o_retire_cnt == '1) ? o_retire_cnt : o_retire_cnt + 1'b1;

    // rpt never exceeds HALT_REPEAT-1 while running, so the increment cannot overflow
    assign rpt_nxt  = (i_pc_debug == last_pc) ? rpt + 1'b1 : RPT_W'(1);
    assign halt_hit = i_insn_vld && (rpt_nxt == RPT_W'(HALT_REPEAT));
    assign tmo_hit  = (cycle_inc == CNT_W'(TIMEOUT_CYCLES));

`ifdef RUN_CTRL_STALL_EN
    localparam int IDLE_W = $clog2(STALL_LIMIT + 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic [IDLE_W-1:0] idle_nxt;

    assign idle_nxt = i_insn_vld ? '0 : idle_cnt + 1'b1;
    assign hung_hit = !i_insn_vld && (idle_nxt == IDLE_W'(STALL_LIMIT));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            idle_cnt <= '0;
        end else if (i_restart || state != S_RUN) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_nxt;
        end
    end
`else
    // stall detection compiled out: false for any legal STALL_LIMIT
    assign hung_hit = (STALL_LIMIT < 0);
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= S_HOLD;
            hold_cnt     <= '0;
            last_pc      <= '0;
            rpt          <= '0;
            o_core_rstn  <= 1'b0;
            o_done       <= 1'b0;
            o_status     <= 2'b00;
            o_cycle_cnt  <= '0;
            o_retire_cnt <= '0;
            o_halt_pc    <= '0;
        end else if (i_restart) begin
            state        <= S_HOLD;
            hold_cnt     <= '0;
            last_pc      <= '0;
            rpt          <= '0;
            o_core_rstn  <= 1'b0;
            o_done       <= 1'b0;
            o_status     <= 2'b00;
            o_cycle_cnt  <= '0;
            o_retire_cnt <= '0;
            o_halt_pc    <= '0;
        end else begin
            case (state)
                S_HOLD: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
                        state       <= S_RUN;
                        o_core_rstn <= 1'b1;
                    end
                end
                S_RUN: begin
                    o_cycle_cnt <= cycle_inc;
                    if (i_insn_vld) begin
                        o_retire_cnt <= retire_inc;
                        last_pc      <= i_pc_debug;
                        rpt          <= rpt_nxt;
                    end
                    if (halt_hit) begin
                        state     <= S_HALTED;
                        o_status  <= 2'b01;
                        o_done    <= 1'b1;
                        o_halt_pc <= i_pc_debug;
                    end else if (hung_hit) begin
                        state    <= S_HUNG;
                        o_status <= 2'b11;
                        o_done   <= 1'b1;
                    end else if (tmo_hit) begin
                        state    <= S_TIMEOUT;
                        o_status <= 2'b10;
                        o_done   <= 1'b1;
                    end
                end
                default: begin
                    // terminal states are sticky; core stays out of reset
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed scenarios plus randomized retire streams against a windowed reference model.
module tb_run_ctrl;

    localparam int RST = 4;
    localparam int TO  = 20;
    localparam int HR  = 4;
    localparam int SL  = 8;
    localparam int CW  = 32;
`ifdef RUN_CTRL_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          restart = 1'b0;
    logic          vld = 1'b0;
    logic [31:0]   pc = '0;
    logic          core_rstn;
    logic          done;
    logic [1:0]    status;
    logic [CW-1:0] cycle_cnt;
    logic [CW-1:0] retire_cnt;
    logic [31:0]   halt_pc;

    int checks = 0;
    int failures = 0;

    int          seq_n;
    logic        seq_vld [0:63];
    logic [31:0] seq_pc  [0:63];

    always #5 clk = ~clk;

    run_ctrl #(
        .RST_CYCLES    (RST),
        .TIMEOUT_CYCLES(TO),
        .HALT_REPEAT   (HR),
        .STALL_LIMIT   (SL),
        .CNT_W         (CW)
    ) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_restart   (restart),
        .i_pc_debug  (pc),
        .i_insn_vld  (vld),
        .o_core_rstn (core_rstn),
        .o_done      (done),
        .o_status    (status),
        .o_cycle_cnt (cycle_cnt),
        .o_retire_cnt(retire_cnt),
        .o_halt_pc   (halt_pc)
    );

    task automatic reset_to_run();
        rstn = 1'b0; restart = 1'b0; vld = 1'b0; pc = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (RST) @(posedge clk);
        #1;
        checks++;
        if (core_rstn !== 1'b1) begin
            failures++;
            $display("FAIL run_entry core_rstn got %b want 1", core_rstn);
        end
    endtask

    // Reference: terminal condition judged from windows over the retired-PC history.
    task automatic run_seq(input string name);
        logic [31:0] rq[$];
        int          e_cyc = 0;
        int          e_ret = 0;
        logic [1:0]  e_st = 2'b00;
        logic [31:0] e_hpc = '0;
        bit          term = 1'b0;
        bit          h, g, t;
        for (int k = 1; k <= seq_n; k++) begin
            vld = seq_vld[k]; pc = seq_pc[k];
            @(posedge clk);
            #1;
            if (!term) begin
                e_cyc++;
                if (seq_vld[k]) begin
                    e_ret++;
                    rq.push_back(seq_pc[k]);
                end
                h = seq_vld[k] && (rq.size() >= HR);
                if (h) for (int j = 1; j < HR; j++) if (rq[rq.size() - 1 - j] != seq_pc[k]) h = 1'b0;
                g = STALL_EN && (k >= SL);
                if (g) for (int j = 0; j < SL; j++) if (seq_vld[k - j]) g = 1'b0;
                t = (e_cyc == TO);
                if (h) begin
                    term = 1'b1; e_st = 2'b01; e_hpc = seq_pc[k];
                end else if (g) begin
                    term = 1'b1; e_st = 2'b11;
                end else if (t) begin
                    term = 1'b1; e_st = 2'b10;
                end
            end
            checks++;
            if (status !== e_st) begin
                failures++;
                $display("FAIL %s k=%0d status got %b want %b", name, k, status, e_st);
            end
            checks++;
            if (done !== (e_st != 2'b00)) begin
                failures++;
                $display("FAIL %s k=%0d done got %b want %b", name, k, done, e_st != 2'b00);
            end
            checks++;
            if (cycle_cnt !== CW'(e_cyc)) begin
                failures++;
                $display("FAIL %s k=%0d cycle_cnt got %0d want %0d", name, k, cycle_cnt, e_cyc);
            end
            checks++;
            if (retire_cnt !== CW'(e_ret)) begin
                failures++;
                $display("FAIL %s k=%0d retire_cnt got %0d want %0d", name, k, retire_cnt, e_ret);
            end
            checks++;
            if (halt_pc !== e_hpc) begin
                failures++;
                $display("FAIL %s k=%0d halt_pc got %h want %h", name, k, halt_pc, e_hpc);
            end
            checks++;
            if (core_rstn !== 1'b1) begin
                failures++;
                $display("FAIL %s k=%0d core_rstn got %b want 1", name, k, core_rstn);
            end
        end
        vld = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; restart = 1'b0; vld = 1'b1; pc = 32'h10;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({core_rstn, done, status, cycle_cnt, retire_cnt, halt_pc} !== '0) begin
            failures++;
            $display("FAIL reset outputs got rstn=%b done=%b st=%b cyc=%0d ret=%0d hpc=%h want all 0",
                     core_rstn, done, status, cycle_cnt, retire_cnt, halt_pc);
        end
        rstn = 1'b1;
        for (int e = 1; e <= RST; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (core_rstn !== (e == RST)) begin
                failures++;
                $display("FAIL reset_release edge=%0d core_rstn got %b want %b", e, core_rstn, e == RST);
            end
            checks++;
            if (cycle_cnt !== '0 || retire_cnt !== '0) begin
                failures++;
                $display("FAIL reset_hold edge=%0d cyc=%0d ret=%0d want 0 0", e, cycle_cnt, retire_cnt);
            end
        end
        vld = 1'b0;
    endtask

    task automatic test_halt();
        logic [31:0] pcs [0:9];
        pcs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'hC, 32'hC, 32'hC, 32'h40, 32'h40};
        reset_to_run();
        seq_n = 10;
        for (int k = 1; k <= 10; k++) begin
            seq_vld[k] = 1'b1; seq_pc[k] = pcs[k-1];
        end
        run_seq("halt");
        checks++;
        if (status !== 2'b01 || halt_pc !== 32'hC || retire_cnt !== 7 || cycle_cnt !== 7 || done !== 1'b1) begin
            failures++;
            $display("FAIL halt_final st=%b hpc=%h ret=%0d cyc=%0d done=%b want 01 c 7 7 1",
                     status, halt_pc, retire_cnt, cycle_cnt, done);
        end
    endtask

    task automatic test_timeout();
        reset_to_run();
        seq_n = 25;
        for (int k = 1; k <= 25; k++) begin
            seq_vld[k] = 1'b1; seq_pc[k] = 32'h100 + 4 * k;
        end
        run_seq("timeout");
        checks++;
        if (status !== 2'b10 || cycle_cnt !== TO || retire_cnt !== TO) begin
            failures++;
            $display("FAIL timeout_final st=%b cyc=%0d ret=%0d want 10 20 20", status, cycle_cnt, retire_cnt);
        end
    endtask

    task automatic test_halt_vs_timeout();
        reset_to_run();
        seq_n = 23;
        for (int k = 1; k <= 23; k++) begin
            seq_vld[k] = 1'b1; seq_pc[k] = (k > 16) ? 32'h200 : 4 * k;
        end
        run_seq("halt_vs_timeout");
        checks++;
        if (status !== 2'b01 || cycle_cnt !== TO || halt_pc !== 32'h200) begin
            failures++;
            $display("FAIL halt_wins st=%b cyc=%0d hpc=%h want 01 20 200", status, cycle_cnt, halt_pc);
        end
    endtask

    task automatic test_stall();
        reset_to_run();
        seq_n = 25;
        for (int k = 1; k <= 25; k++) begin
            seq_vld[k] = 1'b0; seq_pc[k] = 32'h300;
        end
        run_seq("stall");
        checks++;
        if (status !== (STALL_EN ? 2'b11 : 2'b10) || cycle_cnt !== (STALL_EN ? SL : TO)) begin
            failures++;
            $display("FAIL stall_final st=%b cyc=%0d want %b %0d", status, cycle_cnt,
                     STALL_EN ? 2'b11 : 2'b10, STALL_EN ? SL : TO);
        end
    endtask

    task automatic test_restart();
        reset_to_run();
        seq_n = 10;
        for (int k = 1; k <= 10; k++) begin
            seq_vld[k] = 1'b1; seq_pc[k] = 32'h500 + 4 * k;
        end
        run_seq("pre_restart");
        restart = 1'b1; vld = 1'b1; pc = 32'h44;
        @(posedge clk);
        #1;
        restart = 1'b0;
        checks++;
        if (core_rstn !== 1'b0 || cycle_cnt !== '0 || retire_cnt !== '0 || status !== 2'b00) begin
            failures++;
            $display("FAIL restart_edge rstn=%b cyc=%0d ret=%0d st=%b want 0 0 0 00",
                     core_rstn, cycle_cnt, retire_cnt, status);
        end
        for (int e = 1; e <= RST; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (core_rstn !== (e == RST) || cycle_cnt !== '0 || retire_cnt !== '0) begin
                failures++;
                $display("FAIL restart_hold edge=%0d rstn=%b cyc=%0d ret=%0d want %b 0 0",
                         e, core_rstn, cycle_cnt, retire_cnt, e == RST);
            end
        end
        seq_n = 6;
        for (int k = 1; k <= 6; k++) begin
            seq_vld[k] = 1'b1; seq_pc[k] = (k < 3) ? 32'h600 + 4 * k : 32'h0;
        end
        run_seq("post_restart");
        // restart must clear a terminal state on the very next edge
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        checks++;
        if (status !== 2'b00 || done !== 1'b0 || halt_pc !== '0 || core_rstn !== 1'b0) begin
            failures++;
            $display("FAIL restart_terminal st=%b done=%b hpc=%h rstn=%b want 00 0 0 0",
                     status, done, halt_pc, core_rstn);
        end
    endtask

    task automatic test_random();
        int mode;
        for (int it = 0; it < 10; it++) begin
            reset_to_run();
            mode = $urandom_range(0, 2);
            seq_n = 30;
            for (int k = 1; k <= 30; k++) begin
                case (mode)
                    0:       seq_vld[k] = ($urandom_range(0, 3) != 0);
                    1:       seq_vld[k] = ($urandom_range(0, 1) != 0);
                    default: seq_vld[k] = ($urandom_range(0, 7) == 0);
                endcase
                seq_pc[k] = (mode == 2) ? 4 * $urandom_range(0, 7) : 4 * $urandom_range(0, 2);
            end
            run_seq($sformatf("random%0d", it));
        end
    endtask

    initial begin
        test_reset();
        test_halt();
        test_timeout();
        test_halt_vs_timeout();
        test_stall();
        test_restart();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
